dtlb_stage: RTL and testbench
=============================

Name: dtlb_stage

Overview:
- Translation (TL) stage of the data pipeline. Sits directly downstream of the EXE→TL latch and consumes its outputs.
- Holds a small fully-associative data TLB, managed by software through tlbwrite instructions.
- Translates the memory-op virtual address and registers the result into the TL→cache latch.
- On a miss it flags a dTLB fault and squashes younger memory ops until the pipeline is killed.

Parameters:
- N_ENTRIES, 4, number of dTLB entries (power of two, ≥2).
- PPN_W, 8, physical page number width; physical address = PPN_W+12 bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- kill_i  in  1  pipeline flush (exception/branch)
- stall_core_i  in  1  global stall
- supervisor_i  in  1  1 = translation bypassed (PA = VA[PPN_W+11:0])
- tlb_flush_i  in  1  invalidate all entries
- tl_cache_enable_i  in  1  memory op valid
- tl_cache_addr_i  in  32  virtual address
- tl_write_addr_i  in  5  destination register
- tl_int_write_enable_i  in  1  register write enable
- tl_store_data_i  in  32  store data
- tl_tlbwrite_i  in  1  tlbwrite instruction
- tl_idtlb_i  in  1  1 = dTLB target, 0 = iTLB (ignored here)
- tl_read_data_a_i  in  32  tlbwrite VA
- tl_read_data_b_i  in  32  tlbwrite PA
- tl_instruction_i  in  32  instruction
- tl_pc_i  in  32  PC
- c_cache_enable_o  out  1  cache access valid
- c_paddr_o  out  PPN_W+12  physical address
- c_write_addr_o  out  5  passthrough
- c_int_write_enable_o  out  1  gated register write enable
- c_store_data_o  out  32  passthrough
- c_instruction_o  out  32  passthrough
- c_pc_o  out  32  passthrough
- c_dtlb_miss_o  out  1  translation fault for this instruction
- c_miss_vaddr_o  out  32  faulting VA (to the exception unit)

Behaviour:
Registered outputs
- All outputs are registered; latency is 1 cycle.
- Reset (rst_i) clears every output to 0, all entry valid bits, and the victim pointer, and sets the FSM to RUN.
- Priority: rst_i > kill_i > stall_core_i.

Lookup
- Combinational compare of VPN = tl_cache_addr_i[31:12] against all valid entries.
- Hit: PA = {PPN, VA[11:0]}.
- Lookup uses contents from before any write in the same cycle.

tlbwrite
- Applies when tl_tlbwrite_i & tl_idtlb_i & !stall_core_i & !kill_i & FSM = RUN.
- Entry written: VPN = read_data_a[31:12], PPN = read_data_b[PPN_W+11:12], valid = 1.
- Slot selection, in order:
  - an existing entry with a matching VPN is overwritten, so duplicates never exist;
  - otherwise the lowest-index invalid entry;
  - otherwise the entry at the victim pointer, which then increments mod N_ENTRIES (wraps N-1 → 0).
- If tlb_flush_i and a write occur in the same cycle, the flush applies first and the write then lands in entry 0.

FSM
- RUN, non-stalled cycle, tl_cache_enable_i & !supervisor_i:
  - hit → outputs forwarded, c_dtlb_miss_o = 0;
  - miss → c_dtlb_miss_o = 1, c_miss_vaddr_o = VA, c_cache_enable_o = 0, c_int_write_enable_o = 0; instruction and PC still forwarded; go to FAULT.
- FAULT: every incoming instruction is converted to a bubble (all outputs 0, no TLB write). Stay in FAULT until kill_i, which returns to RUN. The fault is reported exactly once.
- Non-memory ops in RUN: c_cache_enable_o = 0; c_int_write_enable_o passes through.
- Supervisor mode: never misses.

Stall, kill and flush
- stall_core_i: outputs, TLB contents, pointer and FSM all hold; tlb_flush_i is ignored.
- kill_i: outputs cleared to 0, FSM → RUN, no TLB write. TLB contents are kept.
- tlb_flush_i (not stalled): all valid bits cleared; the victim pointer is not reset.

Decomposition:
- Shared package vi_mem_pkg holds:
  - PAGE_OFFSET_W = 12, VPN_W = 20;
  - opcode constants OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011;
  - a tlb_entry_t struct {valid, vpn, ppn}.
- One sub-module, tlb_cam: the entry array, match vector, write-slot selection and victim pointer. It is reusable by the future itlb_stage.
- The FSM and output latch live in dtlb_stage.

Test Plan:
- Reset, then tlbwrite VA = 0x00005000 / PA = 0x00003000, then a load at VA 0x00005ABC → next cycle c_paddr_o = 0x03ABC, c_cache_enable_o = 1, c_dtlb_miss_o = 0.
- Load at VA 0x00009010 with an empty TLB → c_dtlb_miss_o = 1, c_miss_vaddr_o = 0x00009010, c_int_write_enable_o = 0. Two following stores → c_cache_enable_o = 0. Then kill_i → RUN; a retried load after the matching tlbwrite hits.
- Five tlbwrites with distinct VPNs 1..5 (N = 4) → VPN 1 evicted, lookup of VPN 1 misses, VPN 5 hits in entry 0, victim pointer = 1. A sixth write to VPN 3 overwrites entry 2 and leaves the pointer unchanged.
- tlbwrite and load to the same VPN in one cycle on an empty TLB → the load misses; a load one cycle later hits.
- stall_core_i held 3 cycles during a tlbwrite → no entry written and outputs frozen; after the stall is released, the write occurs once.
- supervisor_i = 1, load at VA 0x12345678 with an empty TLB → c_paddr_o = 0x45678, no miss. A concurrent tlb_flush_i clears all valid bits, and a later user-mode lookup misses.

Source files
------------

// File: rtl/vi_mem_pkg.sv
// Shared memory-pipeline definitions: page geometry, opcodes, TLB entry layout.
package vi_mem_pkg;

  localparam int unsigned PAGE_OFFSET_W = 12;
  localparam int unsigned VPN_W         = 20;
  // Widest PPN any stage may use; an entry stores the stage's PPN zero-extended.
  localparam int unsigned PPN_MAX_W     = 20;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic                 valid;
    logic [VPN_W-1:0]     vpn;
    logic [PPN_MAX_W-1:0] ppn;
  } tlb_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } tl_state_e;

endpackage

// File: rtl/dtlb_stage_if.sv
// EXE->TL latch outputs in, TL->cache latch outputs out.
interface dtlb_stage_if #(
  parameter int unsigned PPN_W = 8
);

  logic              tl_cache_enable_i;
  logic [31:0]       tl_cache_addr_i;
  logic [4:0]        tl_write_addr_i;
  logic              tl_int_write_enable_i;
  logic [31:0]       tl_store_data_i;
  logic              tl_tlbwrite_i;
  logic              tl_idtlb_i;
  logic [31:0]       tl_read_data_a_i;
  logic [31:0]       tl_read_data_b_i;
  logic [31:0]       tl_instruction_i;
  logic [31:0]       tl_pc_i;

  logic              c_cache_enable_o;
  logic [PPN_W+11:0] c_paddr_o;
  logic [4:0]        c_write_addr_o;
  logic              c_int_write_enable_o;
  logic [31:0]       c_store_data_o;
  logic [31:0]       c_instruction_o;
  logic [31:0]       c_pc_o;
  logic              c_dtlb_miss_o;
  logic [31:0]       c_miss_vaddr_o;

  modport master (
    output tl_cache_enable_i, tl_cache_addr_i, tl_write_addr_i, tl_int_write_enable_i,
           tl_store_data_i, tl_tlbwrite_i, tl_idtlb_i, tl_read_data_a_i,
           tl_read_data_b_i, tl_instruction_i, tl_pc_i,
    input  c_cache_enable_o, c_paddr_o, c_write_addr_o, c_int_write_enable_o,
           c_store_data_o, c_instruction_o, c_pc_o, c_dtlb_miss_o, c_miss_vaddr_o
  );

  modport slave (
    input  tl_cache_enable_i, tl_cache_addr_i, tl_write_addr_i, tl_int_write_enable_i,
           tl_store_data_i, tl_tlbwrite_i, tl_idtlb_i, tl_read_data_a_i,
           tl_read_data_b_i, tl_instruction_i, tl_pc_i,
    output c_cache_enable_o, c_paddr_o, c_write_addr_o, c_int_write_enable_o,
           c_store_data_o, c_instruction_o, c_pc_o, c_dtlb_miss_o, c_miss_vaddr_o
  );

endinterface

// File: rtl/dtlb_stage_tlb_cam.sv
// Fully-associative TLB array: lookup match, write-slot choice, round-robin victim.
module tlb_cam
  import vi_mem_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 4,
  parameter int unsigned PPN_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             we_i,
  input  logic [VPN_W-1:0] wr_vpn_i,
  input  logic [PPN_W-1:0] wr_ppn_i,
  input  logic [VPN_W-1:0] lu_vpn_i,
  output logic             hit_o,
  output logic [PPN_W-1:0] hit_ppn_o
);

  localparam int unsigned IDX_W = $clog2(N_ENTRIES);

  tlb_entry_t           entries [N_ENTRIES];
  logic [IDX_W-1:0]     victim_q;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     match_idx;
  logic [IDX_W-1:0]     free_idx;
  logic                 any_match;
  logic                 any_free;
  logic                 bump_victim;
  logic [PPN_MAX_W-1:0] hit_ppn_full;
  logic                 unused_ppn_hi;

  // Lookup against stored contents; VPNs are unique so at most one entry matches.
  always_comb begin
    hit_o        = 1'b0;
    hit_ppn_full = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (entries[i].valid && entries[i].vpn == lu_vpn_i) begin
        hit_o        = 1'b1;
        hit_ppn_full = hit_ppn_full | entries[i].ppn;
      end
    end
  end

  assign hit_ppn_o     = hit_ppn_full[PPN_W-1:0];
  assign unused_ppn_hi = ^(hit_ppn_full >> PPN_W);

  // Write slot: same-VPN entry, else lowest free, else victim. A same-cycle
  // flush makes every entry look free, so the write lands in entry 0.
  always_comb begin
    any_match = 1'b0;
    any_free  = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    for (int unsigned i = N_ENTRIES; i > 0; i--) begin
      if (!entries[i-1].valid || flush_i) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i-1);
      end else if (entries[i-1].vpn == wr_vpn_i) begin
        any_match = 1'b1;
        match_idx = IDX_W'(i-1);
      end
    end
    bump_victim = 1'b0;
    if (any_match) begin
      wr_idx = match_idx;
    end else if (any_free) begin
      wr_idx = free_idx;
    end else begin
      wr_idx      = victim_q;
      bump_victim = 1'b1;
    end
  end

  // Entry array and victim pointer; flush clears valids but keeps the pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) entries[i].valid <= 1'b0;
      victim_q <= '0;
    end else begin
      if (flush_i) begin
        for (int unsigned i = 0; i < N_ENTRIES; i++) entries[i].valid <= 1'b0;
      end
      if (we_i) begin
        entries[wr_idx] <= '{valid: 1'b1, vpn: wr_vpn_i, ppn: PPN_MAX_W'(wr_ppn_i)};
        if (bump_victim) victim_q <= victim_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtlb_stage.sv
// Data-pipeline translation stage: dTLB lookup, fault FSM and TL->cache latch.
module dtlb_stage
  import vi_mem_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 4,
  parameter int unsigned PPN_W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         kill_i,
  input  logic         stall_core_i,
  input  logic         supervisor_i,
  input  logic         tlb_flush_i,
  dtlb_stage_if.slave  bus
);

  typedef struct packed {
    logic              cache_en;
    logic [PPN_W+11:0] paddr;
    logic [4:0]        write_addr;
    logic              iwe;
    logic [31:0]       store_data;
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic              miss;
    logic [31:0]       miss_vaddr;
  } tl_out_t;

  tl_state_e         state_q, state_d;
  tl_out_t           out_q, out_d;
  logic              hit;
  logic [PPN_W-1:0]  hit_ppn;
  logic              xl_miss;
  logic              tlb_we;
  logic              flush_en;
  logic [PPN_W+11:0] tr_paddr;
  logic              unused_wr_bits;

  assign xl_miss  = bus.tl_cache_enable_i && !supervisor_i && !hit;
  assign tlb_we   = bus.tl_tlbwrite_i && bus.tl_idtlb_i && !stall_core_i && !kill_i
                    && (state_q == ST_RUN);
  assign flush_en = tlb_flush_i && !stall_core_i && !kill_i;
  assign unused_wr_bits = ^{bus.tl_read_data_a_i[PAGE_OFFSET_W-1:0],
                            bus.tl_read_data_b_i[PAGE_OFFSET_W-1:0],
                            bus.tl_read_data_b_i >> (PPN_W + PAGE_OFFSET_W)};

  tlb_cam #(
    .N_ENTRIES (N_ENTRIES),
    .PPN_W     (PPN_W)
  ) u_cam (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_en),
    .we_i      (tlb_we),
    .wr_vpn_i  (bus.tl_read_data_a_i[31:PAGE_OFFSET_W]),
    .wr_ppn_i  (bus.tl_read_data_b_i[PPN_W+11:PAGE_OFFSET_W]),
    .lu_vpn_i  (bus.tl_cache_addr_i[31:PAGE_OFFSET_W]),
    .hit_o     (hit),
    .hit_ppn_o (hit_ppn)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: a user-mode miss in RUN enters FAULT; only kill leaves it.
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = ST_RUN;
    end else if (!stall_core_i && state_q == ST_RUN && xl_miss) begin
      state_d = ST_FAULT;
    end
  end

  // Next latch contents: forward, report the fault, or bubble while in FAULT.
  always_comb begin
    out_d = '0;
    if (supervisor_i) begin
      tr_paddr = bus.tl_cache_addr_i[PPN_W+11:0];
    end else if (hit) begin
      tr_paddr = {hit_ppn, bus.tl_cache_addr_i[PAGE_OFFSET_W-1:0]};
    end else begin
      tr_paddr = '0;
    end
    if (state_q == ST_RUN) begin
      out_d.instr = bus.tl_instruction_i;
      out_d.pc    = bus.tl_pc_i;
      if (xl_miss) begin
        out_d.miss       = 1'b1;
        out_d.miss_vaddr = bus.tl_cache_addr_i;
      end else begin
        out_d.cache_en   = bus.tl_cache_enable_i;
        out_d.paddr      = tr_paddr;
        out_d.write_addr = bus.tl_write_addr_i;
        out_d.iwe        = bus.tl_int_write_enable_i;
        out_d.store_data = bus.tl_store_data_i;
      end
    end
  end

  // TL->cache latch: reset and kill clear it, stall holds it.
  always_ff @(posedge clk_i) begin
    if (rst_i || kill_i) begin
      out_q <= '0;
    end else if (!stall_core_i) begin
      out_q <= out_d;
    end
  end

  assign bus.c_cache_enable_o     = out_q.cache_en;
  assign bus.c_paddr_o            = out_q.paddr;
  assign bus.c_write_addr_o       = out_q.write_addr;
  assign bus.c_int_write_enable_o = out_q.iwe;
  assign bus.c_store_data_o       = out_q.store_data;
  assign bus.c_instruction_o      = out_q.instr;
  assign bus.c_pc_o               = out_q.pc;
  assign bus.c_dtlb_miss_o        = out_q.miss;
  assign bus.c_miss_vaddr_o       = out_q.miss_vaddr;

endmodule

// File: tb/tb_dtlb_stage.sv
// Self-checking bench for dtlb_stage: directed scenarios plus random traffic vs. a reference model.
module tb_dtlb_stage;
  import vi_mem_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 8;

  logic clk = 1'b0;
  logic rst, kill, stall, sup, flush;
  int   errors = 0;
  int   checks = 0;

  dtlb_stage_if #(.PPN_W(PW)) bus ();

  dtlb_stage #(.N_ENTRIES(N), .PPN_W(PW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .kill_i       (kill),
    .stall_core_i (stall),
    .supervisor_i (sup),
    .tlb_flush_i  (flush),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Reference model: TLB as plain arrays, fault flag, expected latch contents.
  bit          m_valid [N];
  int unsigned m_vpn   [N];
  int unsigned m_ppn   [N];
  int unsigned m_vic;
  bit          m_fault;

  logic [31:0] e_cen, e_paddr, e_waddr, e_iwe, e_sdata, e_instr, e_pc, e_miss, e_mva;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    e_cen = 0; e_paddr = 0; e_waddr = 0; e_iwe = 0; e_sdata = 0;
    e_instr = 0; e_pc = 0; e_miss = 0; e_mva = 0;
  endtask

  task automatic model_write(input int unsigned vpn, input int unsigned ppn);
    int slot = -1;
    for (int i = 0; i < N; i++) if (m_valid[i] && m_vpn[i] == vpn) slot = i;
    if (slot < 0) for (int i = 0; i < N; i++) if (!m_valid[i] && slot < 0) slot = i;
    if (slot < 0) begin
      slot  = int'(m_vic);
      m_vic = (m_vic + 1) % N;
    end
    m_valid[slot] = 1'b1;
    m_vpn[slot]   = vpn;
    m_ppn[slot]   = ppn;
  endtask

  // Advance the model by one clock using the currently driven inputs, then compare.
  task automatic cycle();
    int unsigned va, vpn, hppn;
    bit hit, miss;
    va = bus.tl_cache_addr_i;
    if (rst) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_vic = 0; m_fault = 1'b0;
      clear_exp();
    end else if (kill) begin
      m_fault = 1'b0;
      clear_exp();
    end else if (!stall) begin
      vpn = va >> 12; hit = 1'b0; hppn = 0;
      for (int i = 0; i < N; i++) if (m_valid[i] && m_vpn[i] == vpn) begin hit = 1'b1; hppn = m_ppn[i]; end
      miss = bus.tl_cache_enable_i && !sup && !hit;
      clear_exp();
      if (!m_fault) begin
        e_instr = bus.tl_instruction_i;
        e_pc    = bus.tl_pc_i;
        if (miss) begin
          e_miss = 1; e_mva = va;
        end else begin
          e_cen   = {31'd0, bus.tl_cache_enable_i};
          e_paddr = sup ? (va % (1 << (PW + 12))) : (hit ? ((hppn << 12) + (va % 4096)) : 0);
          e_waddr = {27'd0, bus.tl_write_addr_i};
          e_iwe   = {31'd0, bus.tl_int_write_enable_i};
          e_sdata = bus.tl_store_data_i;
        end
      end
      if (flush) for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      if (!m_fault && bus.tl_tlbwrite_i && bus.tl_idtlb_i)
        model_write(bus.tl_read_data_a_i >> 12, (bus.tl_read_data_b_i >> 12) % (1 << PW));
      if (miss) m_fault = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("cache_en",   32'(bus.c_cache_enable_o),     e_cen);
    chk("paddr",      32'(bus.c_paddr_o),            e_paddr);
    chk("write_addr", 32'(bus.c_write_addr_o),       e_waddr);
    chk("iwe",        32'(bus.c_int_write_enable_o), e_iwe);
    chk("store_data", bus.c_store_data_o,            e_sdata);
    chk("instr",      bus.c_instruction_o,           e_instr);
    chk("pc",         bus.c_pc_o,                    e_pc);
    chk("miss",       32'(bus.c_dtlb_miss_o),        e_miss);
    chk("miss_vaddr", bus.c_miss_vaddr_o,            e_mva);
  endtask

  task automatic idle();
    rst = 0; kill = 0; stall = 0; sup = 0; flush = 0;
    bus.tl_cache_enable_i = 0; bus.tl_cache_addr_i = 0; bus.tl_write_addr_i = 0;
    bus.tl_int_write_enable_i = 0; bus.tl_store_data_i = 0; bus.tl_tlbwrite_i = 0;
    bus.tl_idtlb_i = 0; bus.tl_read_data_a_i = 0; bus.tl_read_data_b_i = 0;
    bus.tl_instruction_i = $urandom; bus.tl_pc_i = $urandom;
  endtask

  task automatic set_load(input logic [31:0] va);
    idle();
    bus.tl_cache_enable_i = 1; bus.tl_cache_addr_i = va; bus.tl_int_write_enable_i = 1;
    bus.tl_write_addr_i = 5'($urandom_range(1, 31));
    bus.tl_instruction_i = {$urandom_range(0, 33554431), OPC_LOAD};
  endtask

  task automatic set_store(input logic [31:0] va);
    idle();
    bus.tl_cache_enable_i = 1; bus.tl_cache_addr_i = va; bus.tl_store_data_i = $urandom;
    bus.tl_instruction_i = {$urandom_range(0, 33554431), OPC_STORE};
  endtask

  task automatic set_tlbw(input logic [31:0] va, input logic [31:0] pa);
    idle();
    bus.tl_tlbwrite_i = 1; bus.tl_idtlb_i = 1;
    bus.tl_read_data_a_i = va; bus.tl_read_data_b_i = pa;
  endtask

  task automatic do_kill();
    idle(); kill = 1; cycle();
  endtask

  task automatic do_flush();
    idle(); flush = 1; cycle();
  endtask

  initial begin
    // Reset state
    idle(); rst = 1; cycle(); cycle();
    chk("rst_cache_en", 32'(bus.c_cache_enable_o), 0);
    chk("rst_miss", 32'(bus.c_dtlb_miss_o), 0);

    // Basic translation
    set_tlbw(32'h0000_5000, 32'h0000_3000); cycle();
    set_load(32'h0000_5ABC); cycle();
    chk("t1_paddr", 32'(bus.c_paddr_o), 32'h03ABC);
    chk("t1_cen", 32'(bus.c_cache_enable_o), 1);
    chk("t1_miss", 32'(bus.c_dtlb_miss_o), 0);

    // Miss, squash of younger ops, kill, retry
    do_flush();
    set_load(32'h0000_9010); cycle();
    chk("t2_miss", 32'(bus.c_dtlb_miss_o), 1);
    chk("t2_mva", bus.c_miss_vaddr_o, 32'h0000_9010);
    chk("t2_iwe", 32'(bus.c_int_write_enable_o), 0);
    set_store(32'h0000_5000); cycle();
    chk("t2_st1_cen", 32'(bus.c_cache_enable_o), 0);
    chk("t2_st1_miss", 32'(bus.c_dtlb_miss_o), 0);
    set_store(32'h0000_5004); cycle();
    chk("t2_st2_cen", 32'(bus.c_cache_enable_o), 0);
    do_kill();
    set_tlbw(32'h0000_9000, 32'h0000_7000); cycle();
    set_load(32'h0000_9010); cycle();
    chk("t2_retry_paddr", 32'(bus.c_paddr_o), 32'h07010);
    chk("t2_retry_miss", 32'(bus.c_dtlb_miss_o), 0);

    // Replacement: five writes into four entries, then same-VPN overwrite
    do_flush();
    for (int unsigned v = 1; v <= 5; v++) begin
      set_tlbw(v << 12, (32'h10 + v) << 12); cycle();
    end
    set_load(32'h0000_1000); cycle();
    chk("t3_vpn1_evicted", 32'(bus.c_dtlb_miss_o), 1);
    do_kill();
    set_load(32'h0000_5008); cycle();
    chk("t3_vpn5_paddr", 32'(bus.c_paddr_o), 32'h15008);
    set_tlbw(32'h0000_3000, 32'h0004_4000); cycle();
    set_load(32'h0000_3020); cycle();
    chk("t3_vpn3_new", 32'(bus.c_paddr_o), 32'h44020);
    set_tlbw(32'h0000_6000, 32'h0006_6000); cycle();
    set_load(32'h0000_2000); cycle();
    chk("t3_vpn2_evicted", 32'(bus.c_dtlb_miss_o), 1);
    do_kill();
    set_load(32'h0000_4004); cycle();
    chk("t3_vpn4_paddr", 32'(bus.c_paddr_o), 32'h14004);

    // Write and load to the same VPN in one cycle: lookup sees old contents
    do_flush();
    set_load(32'h0000_A123);
    bus.tl_tlbwrite_i = 1; bus.tl_idtlb_i = 1;
    bus.tl_read_data_a_i = 32'h0000_A000; bus.tl_read_data_b_i = 32'h0002_2000;
    cycle();
    chk("t4_same_cycle_miss", 32'(bus.c_dtlb_miss_o), 1);
    do_kill();
    set_load(32'h0000_A123); cycle();
    chk("t4_later_paddr", 32'(bus.c_paddr_o), 32'h22123);

    // Stall during a tlbwrite
    do_flush();
    set_load(32'h0000_B456); sup = 1; cycle();
    chk("t5_sup_paddr", 32'(bus.c_paddr_o), 32'h0B456);
    set_tlbw(32'h0000_B000, 32'h0000_C000); stall = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t5_frozen_paddr", 32'(bus.c_paddr_o), 32'h0B456);
      chk("t5_frozen_cen", 32'(bus.c_cache_enable_o), 1);
    end
    stall = 0; cycle();
    set_load(32'h0000_B456); cycle();
    chk("t5_after_paddr", 32'(bus.c_paddr_o), 32'h0C456);

    // Supervisor bypass with concurrent flush
    set_tlbw(32'h1234_5000, 32'h0007_7000); cycle();
    set_load(32'h1234_5678); sup = 1; flush = 1; cycle();
    chk("t6_sup_paddr", 32'(bus.c_paddr_o), 32'h45678);
    chk("t6_sup_miss", 32'(bus.c_dtlb_miss_o), 0);
    set_load(32'h1234_5678); cycle();
    chk("t6_user_miss", 32'(bus.c_dtlb_miss_o), 1);
    do_kill();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      idle();
      r = $urandom_range(0, 99);
      rst   = (r == 0);
      kill  = (r >= 1 && r < 9);
      stall = ($urandom_range(0, 9) == 0);
      sup   = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 29) == 0);
      bus.tl_cache_enable_i     = 1'($urandom_range(0, 1));
      bus.tl_cache_addr_i       = ($urandom_range(0, 7) << 12) | ($urandom & 32'hFFF);
      if (sup) bus.tl_cache_addr_i = $urandom;
      bus.tl_write_addr_i       = 5'($urandom_range(0, 31));
      bus.tl_int_write_enable_i = 1'($urandom_range(0, 1));
      bus.tl_store_data_i       = $urandom;
      bus.tl_tlbwrite_i         = ($urandom_range(0, 3) == 0);
      bus.tl_idtlb_i            = ($urandom_range(0, 3) != 0);
      bus.tl_read_data_a_i      = ($urandom_range(0, 7) << 12) | ($urandom & 32'hFFF);
      bus.tl_read_data_b_i      = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
